// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage LC-3b core.
// Merges memory wait status, load-use hazards and branch-predictor stall/flush
// requests into per-stage load/squash enables and the PC load. A small FSM
// handles JSR/JMP/TRAP redirects. Saturating counters track mispredicts,
// redirects and memory stall cycles.
module pipe_hazard_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 imem_resp,
  input  logic                 dmem_req,
  input  logic                 dmem_resp,
  input  logic                 bp_stall,
  input  logic                 bp_flush,
  input  logic                 load_use,
  output logic                 load_pc,
  output logic                 load_if_id,
  output logic                 load_id_ex,
  output logic                 load_ex_mem,
  output logic                 load_mem_wb,
  output logic                 squash_if_id,
  output logic                 squash_id_ex,
  output logic                 ct_busy,
  output logic [CNT_WIDTH-1:0] mispredict_count,
  output logic [CNT_WIDTH-1:0] redirect_count,
  output logic [CNT_WIDTH-1:0] mem_stall_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    CT_WAIT  = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   mispredict_q, redirect_q, mem_stall_q;
  logic                   freeze;

  // A pending memory access (either side) stalls the whole pipeline.
  assign freeze = (!imem_resp) | (dmem_req & !dmem_resp);

  function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Enable/squash decode and next-state selection, in priority order.
  always_comb begin
    state_d      = state_q;
    load_pc      = 1'b1;
    load_if_id   = 1'b1;
    load_id_ex   = 1'b1;
    load_ex_mem  = 1'b1;
    load_mem_wb  = 1'b1;
    squash_if_id = 1'b0;
    squash_id_ex = 1'b0;
    ct_busy      = (state_q != RUN);

    if (reset) begin
      load_pc      = 1'b0;
      squash_if_id = 1'b1;
      squash_id_ex = 1'b1;
      ct_busy      = 1'b0;
      state_d      = RUN;
    end else if (freeze) begin
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      load_id_ex   = 1'b0;
      load_ex_mem  = 1'b0;
      load_mem_wb  = 1'b0;
    end else if (bp_flush) begin
      squash_if_id = 1'b1;
      squash_id_ex = 1'b1;
      state_d      = (state_q == CT_WAIT) ? REDIRECT : RUN;
    end else if (load_use) begin
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      squash_id_ex = 1'b1;
      state_d      = (state_q == CT_WAIT) ? CT_WAIT : RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (bp_stall) begin
            load_pc = 1'b0;
            state_d = CT_WAIT;
          end
        end
        CT_WAIT: begin
          load_pc      = 1'b0;
          squash_if_id = 1'b1;
        end
        REDIRECT: begin
          if (bp_stall) begin
            load_pc = 1'b0;
            state_d = CT_WAIT;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State and performance counters; a frozen cycle holds the FSM and only
  // counts the stall, so a flush seen while frozen is not consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      mispredict_q <= '0;
      redirect_q   <= '0;
      mem_stall_q  <= '0;
    end else if (freeze) begin
      mem_stall_q  <= satInc(mem_stall_q);
    end else begin
      state_q <= state_d;
      if (bp_flush) begin
        if (state_q == CT_WAIT) begin
          redirect_q <= satInc(redirect_q);
        end else begin
          mispredict_q <= satInc(mispredict_q);
        end
      end
    end
  end

  assign mispredict_count = mispredict_q;
  assign redirect_count   = redirect_q;
  assign mem_stall_count  = mem_stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios followed by random
// traffic, all checked against a behavioural model of the sequencing rules.
// A second instance with 4-bit counters exercises saturation.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset, imem_resp, dmem_req, dmem_resp, bp_stall, bp_flush, load_use;

  logic aLoadPc, aLoadIfId, aLoadIdEx, aLoadExMem, aLoadMemWb, aSqIfId, aSqIdEx, aBusy;
  logic [15:0] aMis, aRed, aStall;
  logic bLoadPc, bLoadIfId, bLoadIdEx, bLoadExMem, bLoadMemWb, bSqIfId, bSqIdEx, bBusy;
  logic [3:0] bMis, bRed, bStall;

  int nChecks = 0;
  int nFails  = 0;

  // Model: mode 0 = normal flow, 1 = waiting for CT target, 2 = fetching target
  int mMode = 0;
  int mMis = 0, mRed = 0, mStall = 0;
  bit mCountersKnown = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_WIDTH(16)) dutWide (
    .clk(clk), .reset(reset), .imem_resp(imem_resp), .dmem_req(dmem_req),
    .dmem_resp(dmem_resp), .bp_stall(bp_stall), .bp_flush(bp_flush), .load_use(load_use),
    .load_pc(aLoadPc), .load_if_id(aLoadIfId), .load_id_ex(aLoadIdEx),
    .load_ex_mem(aLoadExMem), .load_mem_wb(aLoadMemWb),
    .squash_if_id(aSqIfId), .squash_id_ex(aSqIdEx), .ct_busy(aBusy),
    .mispredict_count(aMis), .redirect_count(aRed), .mem_stall_count(aStall)
  );

  pipe_hazard_ctrl #(.CNT_WIDTH(4)) dutNarrow (
    .clk(clk), .reset(reset), .imem_resp(imem_resp), .dmem_req(dmem_req),
    .dmem_resp(dmem_resp), .bp_stall(bp_stall), .bp_flush(bp_flush), .load_use(load_use),
    .load_pc(bLoadPc), .load_if_id(bLoadIfId), .load_id_ex(bLoadIdEx),
    .load_ex_mem(bLoadExMem), .load_mem_wb(bLoadMemWb),
    .squash_if_id(bSqIfId), .squash_id_ex(bSqIdEx), .ct_busy(bBusy),
    .mispredict_count(bMis), .redirect_count(bRed), .mem_stall_count(bStall)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: observed=%h expected=%h", tag, $time, observed, expected);
    end
  endtask

  function automatic int capAt(input int v, input int width);
    int top;
    top = (1 << width) - 1;
    return (v > top) ? top : v;
  endfunction

  // One cycle: drive inputs after the falling edge, check combinational
  // outputs and current counters mid-cycle, then advance the model.
  task automatic applyStimulus(input bit rst, input bit im, input bit dq, input bit dr,
                               input bit st, input bit fl, input bit lu);
    bit frz;
    bit lp, lif, lrest, sqi, sqe, busy;
    logic [7:0] expVec;
    @(negedge clk);
    reset = rst; imem_resp = im; dmem_req = dq; dmem_resp = dr;
    bp_stall = st; bp_flush = fl; load_use = lu;
    #1;
    frz = !im || (dq && !dr);
    busy = (mMode != 0);
    if (rst) begin
      lp = 0; lif = 1; lrest = 1; sqi = 1; sqe = 1; busy = 0;
    end else if (frz) begin
      lp = 0; lif = 0; lrest = 0; sqi = 0; sqe = 0;
    end else begin
      lp = 1; lif = 1; lrest = 1; sqi = 0; sqe = 0;
      if (fl) begin
        sqi = 1; sqe = 1;
      end else if (lu) begin
        lp = 0; lif = 0; sqe = 1;
      end else if (mMode == 1) begin
        lp = 0; sqi = 1;
      end else if (st) begin
        lp = 0;
      end
    end
    expVec = {lp, lif, lrest, lrest, lrest, sqi, sqe, busy};
    checkOutput("ctl16", {24'd0, aLoadPc, aLoadIfId, aLoadIdEx, aLoadExMem, aLoadMemWb, aSqIfId, aSqIdEx, aBusy}, {24'd0, expVec});
    checkOutput("ctl4",  {24'd0, bLoadPc, bLoadIfId, bLoadIdEx, bLoadExMem, bLoadMemWb, bSqIfId, bSqIdEx, bBusy}, {24'd0, expVec});
    if (mCountersKnown) begin
      checkOutput("mis16",   {16'd0, aMis},   capAt(mMis, 16));
      checkOutput("red16",   {16'd0, aRed},   capAt(mRed, 16));
      checkOutput("stall16", {16'd0, aStall}, capAt(mStall, 16));
      checkOutput("mis4",    {28'd0, bMis},   capAt(mMis, 4));
      checkOutput("red4",    {28'd0, bRed},   capAt(mRed, 4));
      checkOutput("stall4",  {28'd0, bStall}, capAt(mStall, 4));
    end
    if (rst) begin
      mMode = 0; mMis = 0; mRed = 0; mStall = 0; mCountersKnown = 1;
    end else if (frz) begin
      mStall++;
    end else if (fl) begin
      if (mMode == 1) begin
        mRed++; mMode = 2;
      end else begin
        mMis++; mMode = 0;
      end
    end else if (lu) begin
      mMode = (mMode == 1) ? 1 : 0;
    end else if (mMode == 1) begin
      mMode = 1;
    end else if (st) begin
      mMode = 1;
    end else begin
      mMode = 0;
    end
  endtask

  initial begin
    reset = 1; imem_resp = 1; dmem_req = 0; dmem_resp = 0;
    bp_stall = 0; bp_flush = 0; load_use = 0;

    // Reset held two cycles, then idle flow
    repeat (2) applyStimulus(1, 1, 0, 0, 0, 0, 0);
    repeat (2) applyStimulus(0, 1, 0, 0, 0, 0, 0);

    // Single mispredict flush
    applyStimulus(0, 1, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);

    // CT op, three waiting cycles, redirect, then back to normal flow
    applyStimulus(0, 1, 0, 0, 1, 0, 0);
    repeat (3) applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 1, 0);
    repeat (2) applyStimulus(0, 1, 0, 0, 0, 0, 0);

    // Flush held across a data-memory stall, applied once the access completes
    repeat (4) applyStimulus(0, 1, 1, 0, 0, 1, 0);
    applyStimulus(0, 1, 1, 1, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);

    // Flush beats load-use, then load-use alone
    applyStimulus(0, 1, 0, 0, 0, 1, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 1);

    // Long fetch stall saturates the narrow counter
    repeat (20) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);

    // Reset in the middle of a CT wait clears everything
    applyStimulus(0, 1, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);

    // Random traffic with biased event rates
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 79) == 0),
                    ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 5) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
